uart_tx_serializer: RTL
=======================

Name: uart_tx_serializer

Overview:
- Transmit stage directly downstream of the UART TX byte FIFO.
- Pops bytes from the FIFO's registered read port and serialises each one onto txd as a 16550-style frame: start bit, 5–8 data bits LSB first, optional parity, then 1, 1.5 or 2 stop bits.
- Bit timing comes from an external baud-rate enable at OVERSAMPLE x the bit rate.
- Line-control fields come straight from the LCR register.

Parameters:
OVERSAMPLE, 16, baud_tick pulses per bit period; must be even, >=4.

Ports:
clk  input  1  system clock
rst_  input  1  synchronous reset, active-high (sampled on rising clk edge only)
baud_tick  input  1  one-clk enable pulse, OVERSAMPLE per bit
fifo_rempty  input  1  TX FIFO empty flag
fifo_data  input  8  TX FIFO registered read data, valid the clk after fifo_rinc
fifo_rinc  output  1  TX FIFO pop strobe, one clk wide
lcr_wls  input  2  word length: 0=5, 1=6, 2=7, 3=8 bits
lcr_stb  input  1  0=1 stop; 1=1.5 stop if 5-bit word, else 2 stop
lcr_pen  input  1  parity enable
lcr_eps  input  1  even parity select
lcr_sp  input  1  stick parity
lcr_bc  input  1  break control
txd  output  1  serial output, idle high
tx_busy  output  1  frame fetch/shift in progress
temt  output  1  transmitter empty: fifo_rempty and not tx_busy

Behaviour:
- Reset (rst_=1 at clk edge):
  - state=IDLE; txd=1, fifo_rinc=0, tx_busy=0.
  - Tick counter, bit counter and shift register cleared.
  - Reset mid-frame aborts the frame; the byte is lost, and txd returns high on the next clk.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - If !fifo_rempty -> FETCH.
  - txd=1, tx_busy=0.
- FETCH (1 clk):
  - fifo_rinc=1 for this clk only -> LOAD.
  - fifo_rinc is never asserted while fifo_rempty=1.
- LOAD (1 clk):
  - Capture fifo_data into the shift register.
  - Latch lcr_wls/stb/pen/eps/sp into frame-config registers.
  - LCR changes mid-frame have no effect until the next LOAD.
  - Clear the tick counter -> START.
- Bit timing:
  - The tick counter increments on each baud_tick and resets when a bit period completes.
  - START/DATA/PARITY last OVERSAMPLE ticks each.
  - STOP lasts OVERSAMPLE ticks per stop bit; 1.5 stop = 3*OVERSAMPLE/2 ticks.
  - A state advances on the clk edge of the baud_tick that completes its period.
- START: txd=0 -> DATA.
- DATA:
  - txd = shift[0]; shift right at the end of each bit.
  - After wls+5 bits -> PARITY if pen, else STOP.
- PARITY:
  - Even parity (pen=1, sp=0, eps=1): bit = XOR of the active data bits only.
  - Odd parity (eps=0): bit = inverted XOR.
  - Stick parity (sp=1): bit = ~eps.
  - -> STOP.
- STOP: txd=1. At period end -> FETCH if !fifo_rempty, else IDLE.
- Back-to-back frames: 2 clk gap (FETCH, LOAD) with txd high between frames; no baud-tick alignment required.
- Start-bit latency: fifo_rempty falls at cycle N in IDLE -> FETCH at N+1 -> LOAD at N+2 -> txd=0 from N+3.
- tx_busy=1 in all states except IDLE.
- temt is combinational: fifo_rempty & (state==IDLE).
- Break (lcr_bc=1):
  - txd forced 0 combinationally over the FSM output.
  - The FSM keeps running, so the frame still consumes its time.
  - Release restores the normal txd on the same clk.
- txd driven from a register (FSM-decoded, then ANDed with ~lcr_bc); no glitches on state change.

Test Plan:
- 8N1, baud_tick every clk, FIFO byte 0x55 -> fifo_rinc pulses once; txd from start: 0 for 16 clk, then 1,0,1,0,1,0,1,0 each 16 clk, then 1 for 16 clk; temt=1 after STOP.
- 7E1 (wls=2, pen=1, eps=1), byte 0x83 (active bits 0000011) -> 7 data bits 1,1,0,0,0,0,0 LSB first; parity bit 0; one stop; bit 7 ignored.
- 5-bit, stb=1, pen=1, sp=1, eps=0, byte 0x1F -> 5 data ones; parity bit 1; stop high for exactly 24 ticks.
- Two bytes 0xA5, 0x3C queued -> second fifo_rinc exactly 1 clk after the first STOP ends; txd high for exactly 2 clk between stop and next start; tx_busy stays 1 throughout.
- lcr_bc=1 mid-DATA -> txd=0 immediately; FSM completes the frame on schedule; lcr_bc=0 restores txd=1 in STOP.
- rst_ pulsed during DATA of byte 0x00 -> next clk: txd=1, tx_busy=0, fifo_rinc=0; with FIFO non-empty, FETCH resumes after rst_ deasserts and a fresh frame starts.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer.
// Pops bytes from the TX FIFO's registered read port and shifts each one out on
// txd as a 16550-style frame: start, 5-8 data bits LSB first, optional parity,
// then 1, 1.5 or 2 stop bits. Bit timing comes from an external baud_tick
// enable running at OVERSAMPLE x the bit rate.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line idle, waiting for the FIFO to go non-empty
// FETCH  | one-clk pop strobe to the FIFO
// LOAD   | capture FIFO read data, latch line-control fields
// START  | start bit, txd low
// DATA   | data bits, LSB first
// PARITY | parity bit (only when parity is enabled)
// STOP   | stop bit(s): 1, 1.5 or 2 bit periods, txd high
module uart_tx_serializer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       baud_tick,
  input  logic       fifo_rempty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rinc,
  input  logic [1:0] lcr_wls,
  input  logic       lcr_stb,
  input  logic       lcr_pen,
  input  logic       lcr_eps,
  input  logic       lcr_sp,
  input  logic       lcr_bc,
  output logic       txd,
  output logic       tx_busy,
  output logic       temt
);

  // Wide enough for the longest period (two stop bits).
  localparam int TW = $clog2(2 * OVERSAMPLE);

  localparam logic [TW-1:0] BIT_LAST    = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP15_LAST = TW'((3 * OVERSAMPLE) / 2 - 1);
  localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [1:0]      wls_q, wls_d;
  logic            stb_q, stb_d;
  logic            pen_q, pen_d;
  logic            eps_q, eps_d;
  logic            sp_q, sp_d;
  logic            par_q, par_d;
  logic            txd_q, txd_d;

  logic [TW-1:0]   period_last;
  logic [TW-1:0]   stop_last;
  logic            period_done;
  logic [2:0]      data_last;
  logic            par_bit;
  logic            rinc;

  // Only the active data bits contribute to parity.
  function automatic logic [7:0] wls_mask(input logic [1:0] wls);
    logic [7:0] m;
    case (wls)
      2'd0:    m = 8'h1F;
      2'd1:    m = 8'h3F;
      2'd2:    m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Period length and parity bit derived from the latched frame config.
  always_comb begin
    stop_last = BIT_LAST;
    if (stb_q) begin
      stop_last = (wls_q == 2'd0) ? STOP15_LAST : STOP2_LAST;
    end
    period_last = (state_q == STOP) ? stop_last : BIT_LAST;
    period_done = baud_tick && (tick_q == period_last);
    data_last   = {1'b0, wls_q} + 3'd4;
    if (sp_q) begin
      par_bit = ~eps_q;
    end else begin
      par_bit = eps_q ? par_q : ~par_q;
    end
  end

  // Next-state, datapath updates and registered txd decode.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    wls_d    = wls_q;
    stb_d    = stb_q;
    pen_d    = pen_q;
    eps_d    = eps_q;
    sp_d     = sp_q;
    par_d    = par_q;
    rinc     = 1'b0;

    // Common bit-period timing for every shifting state.
    if ((state_q == START) || (state_q == DATA) ||
        (state_q == PARITY) || (state_q == STOP)) begin
      if (baud_tick) begin
        tick_d = period_done ? '0 : tick_q + TW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (!fifo_rempty) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        // Guard against popping an empty FIFO; otherwise pop exactly once.
        if (fifo_rempty) begin
          state_d = IDLE;
        end else begin
          rinc    = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        shift_d  = fifo_data;
        wls_d    = lcr_wls;
        stb_d    = lcr_stb;
        pen_d    = lcr_pen;
        eps_d    = lcr_eps;
        sp_d     = lcr_sp;
        par_d    = ^(fifo_data & wls_mask(lcr_wls));
        tick_d   = '0;
        bitcnt_d = '0;
        state_d  = START;
      end
      START: begin
        if (period_done) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (period_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bitcnt_q == data_last) begin
            state_d = pen_q ? PARITY : STOP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (period_done) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (period_done) begin
          state_d = fifo_rempty ? IDLE : FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // txd is decoded from the next state so the register output lines up
    // with the state it belongs to.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = par_bit;
      default: txd_d = 1'b1;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      wls_q    <= '0;
      stb_q    <= 1'b0;
      pen_q    <= 1'b0;
      eps_q    <= 1'b0;
      sp_q     <= 1'b0;
      par_q    <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      wls_q    <= wls_d;
      stb_q    <= stb_d;
      pen_q    <= pen_d;
      eps_q    <= eps_d;
      sp_q     <= sp_d;
      par_q    <= par_d;
      txd_q    <= txd_d;
    end
  end

  // Break overrides the registered line level without stopping the FSM.
  assign txd       = txd_q & ~lcr_bc;
  assign fifo_rinc = rinc;
  assign tx_busy   = (state_q != IDLE);
  assign temt      = fifo_rempty & (state_q == IDLE);

endmodule
